dcnn_onchip_mem_pipe: RTL and testbench
=======================================

DCNN_ONCHIP_MEM_PIPE -- requirements
Module: dcnn_onchip_mem_pipe

Interface
REQ-001 Parameters SHALL be exactly these three:
  - DATA_W, default 32: word width; a multiple of 8.
  - ADDR_W, default 17: word-address width.
  - DEPTH, default 102400: number of words; 1 <= DEPTH <= 2**ADDR_W.
REQ-002 Parameter OUT_REG, default 1, SHALL select read latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports are:
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high reset.
  - reset_req  in  1  reset-pending request; blocks command acceptance.
  - clken  in  1  command-acceptance enable.
  - chipselect  in  1  slave select.
  - read  in  1  read command.
  - write  in  1  write command.
  - address  in  ADDR_W  word address.
  - byteenable  in  DATA_W/8  per-byte write enable.
  - writedata  in  DATA_W  write data.
  - readdata  out  DATA_W  read data, registered.
  - readdatavalid  out  1  one-cycle qualifier for readdata.
  - parity_err  out  1  sticky parity-error flag.
  - err_count  out  8  saturating parity-error count.

Function
REQ-004 A command SHALL be accepted only on an edge where chipselect=1 and clken=1 and reset_req=0; there is no waitrequest, so every cycle can accept a command.
REQ-005 An accepted write SHALL update exactly the bytes whose byteenable bit is 1 at that edge; other bytes SHALL keep their value.
REQ-006 When read=1 and write=1 are both asserted, the block SHALL perform the write and ignore the read; no readdatavalid SHALL result.
REQ-007 An accepted read SHALL assert readdatavalid for exactly one cycle, 1+OUT_REG cycles after the acceptance edge, with readdata valid in that same cycle.
REQ-008 Reads SHALL be fully pipelined: back-to-back reads SHALL produce back-to-back readdatavalid pulses, in issue order.
REQ-009 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-010 Deasserting clken or asserting reset_req SHALL block only new commands; reads already in flight SHALL still complete on schedule.
REQ-011 A write with address >= DEPTH SHALL be dropped and SHALL not alias onto another word.
REQ-012 A read with address >= DEPTH SHALL return all-zero data, still with readdatavalid asserted.
REQ-013 readdata SHALL hold its last value while readdatavalid=0.

Reset
REQ-014 Reset SHALL clear the following: all pipeline valid bits, readdatavalid (to 0), readdata (to 0), parity_err (to 0) and err_count (to 0).
REQ-015 Reset SHALL not alter memory contents.
REQ-016 Reads in flight when reset is asserted SHALL be discarded and SHALL produce no readdatavalid.
REQ-017 A command presented during a reset cycle SHALL be ignored.

Configuration
REQ-018 The parity feature SHALL be controlled by macro DCNN_ONCHIP_MEM_PARITY_EN.
REQ-019 With DCNN_ONCHIP_MEM_PARITY_EN defined:
  - one even-parity bit SHALL be stored per byte and rewritten with that byte;
  - parity SHALL be checked on every delivered read of an in-range address;
  - any mismatch SHALL set parity_err, sticky until reset;
  - any mismatch SHALL increment err_count once per bad beat, saturating at 255.
REQ-020 Without the macro, no parity storage SHALL exist, and parity_err and err_count SHALL be tied to 0.

Verification
REQ-021 Write addr 5 = 0xDEADBEEF with byteenable 0xF, then read addr 5 with OUT_REG=1 -> readdatavalid at acceptance+2 and readdata=0xDEADBEEF.
REQ-022 Write 0xFFFFFFFF to addr 7, then write 0x11223344 to addr 7 with byteenable 0x5, then read addr 7 -> 0xFF22FF44.
REQ-023 Issue 4 consecutive reads of addrs 0..3 holding 0xA0..0xA3 -> 4 consecutive readdatavalid pulses with data 0xA0,0xA1,0xA2,0xA3.
REQ-024 Issue a read, then drop clken the next cycle while presenting a second read -> first read completes on schedule, second produces no readdatavalid.
REQ-025 Read addr 102400 (DEPTH=102400) -> readdata=0 with readdatavalid=1; write to addr 102400, then read addr 0 -> addr 0 contents unchanged.
REQ-026 With macro defined, force a stored parity bit of addr 9 wrong, then read addr 9 three times -> parity_err=1 and err_count=3; then assert reset -> both return to 0.

Source files
------------

// File: rtl/dcnn_onchip_mem_pipe.sv
// Pipelined single-port on-chip word memory with byte enables and 1- or 2-cycle read latency.
// Optional per-byte even parity storage/checking is enabled by defining DCNN_ONCHIP_MEM_PARITY_EN.
module dcnn_onchip_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 17,
    parameter int DEPTH   = 102400,
    parameter int OUT_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                clken,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                parity_err,
    output logic [7:0]          err_count
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic cmd_ok;
    logic wr_acc;
    logic rd_acc;
    logic in_range;

    // A write that coincides with a read wins; the read is dropped entirely.
    assign cmd_ok   = !reset && chipselect && clken && !reset_req;
    assign wr_acc   = cmd_ok && write;
    assign rd_acc   = cmd_ok && read && !write;
    assign in_range = ({1'b0, address} < DEPTH_L);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    logic              s1_valid;
    logic              s1_in_range;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_data     <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_in_range <= in_range;
                s1_data     <= in_range ? mem[address] : '0;
            end
        end
    end

    logic              fin_valid;
    logic              fin_in_range;
    logic [DATA_W-1:0] fin_data;

`ifdef DCNN_ONCHIP_MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] s1_par;
    logic [NB-1:0] fin_par;
    logic [NB-1:0] fin_calc_par;
    logic          bad_beat;
    logic          parity_err_q;
    logic [7:0]    err_count_q;

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    par_mem[address][b] <= ^writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_par <= '0;
        end else if (rd_acc) begin
            s1_par <= in_range ? par_mem[address] : '0;
        end
    end

    always_comb begin
        fin_calc_par = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            fin_calc_par[b] = ^fin_data[8*b +: 8];
        end
    end

    // Errors are booked on the edge after the bad beat is presented.
    assign bad_beat = fin_valid && fin_in_range && (fin_calc_par != fin_par);

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
        end else if (bad_beat) begin
            parity_err_q <= 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;
`else
    assign parity_err = 1'b0;
    assign err_count  = '0;
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_valid;
            logic              s2_in_range;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_valid    <= 1'b0;
                    s2_in_range <= 1'b0;
                    s2_data     <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_in_range <= s1_in_range;
                        s2_data     <= s1_data;
                    end
                end
            end

`ifdef DCNN_ONCHIP_MEM_PARITY_EN
            logic [NB-1:0] s2_par;
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_par <= '0;
                end else if (s1_valid) begin
                    s2_par <= s1_par;
                end
            end
            assign fin_par = s2_par;
`endif
            assign fin_valid    = s2_valid;
            assign fin_in_range = s2_in_range;
            assign fin_data     = s2_data;
        end else begin : g_no_out_reg
`ifdef DCNN_ONCHIP_MEM_PARITY_EN
            assign fin_par = s1_par;
`endif
            assign fin_valid    = s1_valid;
            assign fin_in_range = s1_in_range;
            assign fin_data     = s1_data;
        end
    endgenerate

    assign readdata      = fin_data;
    assign readdatavalid = fin_valid;

endmodule

// File: tb/tb_dcnn_onchip_mem_pipe.sv
// Randomized self-checking bench for dcnn_onchip_mem_pipe against a queue-based memory model.
// Parity fault injection runs only when DCNN_ONCHIP_MEM_PARITY_EN is defined.
module tb_dcnn_onchip_mem_pipe;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 17;
    localparam int DEPTH   = 102400;
    localparam int OUT_REG = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              reset_req = 1'b0;
    logic              clken = 1'b0;
    logic              chipselect = 1'b0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [3:0]        byteenable = '0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              parity_err;
    logic [7:0]        err_count;

    dcnn_onchip_mem_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .OUT_REG(OUT_REG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_req    (reset_req),
        .clken        (clken),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .address      (address),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .parity_err   (parity_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          bad;
    } beat_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] model [int];
    beat_t       pend [$];
    logic [31:0] last_data = '0;
    int          bad_addr = -1;
    bit          pend_bad = 0;
    int          exp_errc = 0;
    bit          exp_perr = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, then check at negedge.
    task automatic step(input bit rst, input bit cs, input bit rd, input bit wr,
                        input bit ce, input bit rr, input logic [ADDR_W-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        bit    acc;
        bit    ok;
        beat_t b;
        reset = rst; chipselect = cs; read = rd; write = wr;
        clken = ce; reset_req = rr; address = a; byteenable = be; writedata = wd;
        @(posedge clk);
        cyc++;
        ok  = (int'(a) < DEPTH);
        acc = !rst && cs && ce && !rr;
        if (rst) begin
            pend.delete();
            last_data = '0;
            exp_errc  = 0;
            exp_perr  = 0;
        end else begin
            if (pend_bad) begin
                exp_perr = 1;
                if (exp_errc < 255) exp_errc++;
            end
            if (acc && wr) begin
                if (ok) begin
                    logic [31:0] w;
                    w = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                    model[int'(a)] = w;
                    if (int'(a) == bad_addr && be[0]) bad_addr = -1;
                end
            end else if (acc && rd) begin
                b.due  = cyc + OUT_REG;
                b.data = ok ? (model.exists(int'(a)) ? model[int'(a)] : 32'h0) : 32'h0;
                b.bad  = ok && (int'(a) == bad_addr);
                pend.push_back(b);
            end
        end
        pend_bad = 0;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            check_eq("rdv", {31'b0, readdatavalid}, 32'd1);
            check_eq("rdata", readdata, pend[0].data);
            last_data = pend[0].data;
            pend_bad  = pend[0].bad;
            void'(pend.pop_front());
        end else begin
            check_eq("rdv_idle", {31'b0, readdatavalid}, 32'd0);
            check_eq("rdata_hold", readdata, last_data);
        end
        check_eq("perr", {31'b0, parity_err}, {31'b0, exp_perr});
        check_eq("errc", {24'b0, err_count}, 32'(exp_errc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, '0, '0, '0);
    endtask

    task automatic wr_word(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
        step(0, 1, 0, 1, 1, 0, a, be, d);
    endtask

    // Issue one read, wait out the latency, then confirm the delivered word directly.
    task automatic rd_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        step(0, 1, 1, 0, 1, 0, a, '0, '0);
        for (int i = 0; i < OUT_REG; i++) begin
            check_eq({tag, "_early"}, {31'b0, readdatavalid}, 32'd0);
            step(0, 0, 0, 0, 1, 0, '0, '0, '0);
        end
        check_eq({tag, "_v"}, {31'b0, readdatavalid}, 32'd1);
        check_eq(tag, readdata, d);
    endtask

    initial begin
        step(1, 1, 1, 0, 1, 0, 17'd3, 4'hF, 32'h0);
        step(1, 1, 0, 1, 1, 0, 17'd3, 4'hF, 32'h12345678);
        check_eq("reset_rdv", {31'b0, readdatavalid}, 32'd0);
        check_eq("reset_rdata", readdata, 32'd0);
        check_eq("reset_perr", {31'b0, parity_err}, 32'd0);
        check_eq("reset_errc", {24'b0, err_count}, 32'd0);

        wr_word(17'd5, 4'hF, 32'hDEADBEEF);
        rd_expect("full_word", 17'd5, 32'hDEADBEEF);

        wr_word(17'd7, 4'hF, 32'hFFFFFFFF);
        wr_word(17'd7, 4'h5, 32'h11223344);
        rd_expect("byte_en", 17'd7, 32'hFF22FF44);

        for (int i = 0; i < 4; i++) wr_word(17'(i), 4'hF, 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 0, 17'(i), '0, '0);
        idle(3);

        step(0, 1, 1, 0, 1, 0, 17'd5, '0, '0);
        step(0, 1, 1, 0, 0, 0, 17'd7, '0, '0);
        step(0, 1, 1, 0, 1, 1, 17'd7, '0, '0);
        idle(3);

        wr_word(17'd9, 4'hF, 32'h0BADF00D);
        step(0, 1, 1, 1, 1, 0, 17'd9, 4'h3, 32'h00001234);
        rd_expect("rw_collide", 17'd9, 32'h0BAD1234);

        rd_expect("oor_read", 17'(DEPTH), 32'h0);
        wr_word(17'(DEPTH), 4'hF, 32'h55555555);
        rd_expect("oor_alias", 17'd0, 32'hA0);

        step(0, 1, 1, 0, 1, 0, 17'd2, '0, '0);
        step(1, 1, 1, 0, 1, 0, 17'd3, '0, '0);
        idle(3);
        rd_expect("mem_after_reset", 17'd2, 32'hA2);

        for (int i = 0; i < 64; i++) wr_word(17'(i), 4'hF, $urandom);
        for (int n = 0; n < 1500; n++) begin
            logic [ADDR_W-1:0] a;
            if ($urandom_range(15) == 0) a = 17'(DEPTH + int'($urandom_range((1 << ADDR_W) - DEPTH - 1)));
            else a = 17'($urandom_range(63));
            step($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(1) == 1,
                 $urandom_range(2) == 0, $urandom_range(6) != 0, $urandom_range(19) == 0,
                 a, 4'($urandom), $urandom);
        end
        idle(3);

`ifdef DCNN_ONCHIP_MEM_PARITY_EN
        wr_word(17'd9, 4'hF, 32'h00000001);
        idle(1);
        dut.par_mem[9][0] = ~dut.par_mem[9][0];
        bad_addr = 9;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 17'd9, '0, '0);
        idle(3);
        check_eq("par_err_set", {31'b0, parity_err}, 32'd1);
        check_eq("par_err_cnt", {24'b0, err_count}, 32'd3);
        step(1, 0, 0, 0, 1, 0, '0, '0, '0);
        check_eq("par_err_clr", {31'b0, parity_err}, 32'd0);
        check_eq("par_cnt_clr", {24'b0, err_count}, 32'd0);
`endif

        check_eq("drained", 32'(pend.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
